// File: rtl/lcd_bus_writer.sv
// Parallel 8-bit LCD write-strobe generator: turns a valid/ready byte stream into D/dcx/wr cycles.
// Optional 4-entry input FIFO enabled by defining LCD_WR_FIFO_EN; default build writes straight through.
module lcd_bus_writer #(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic       hwclk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_dcx,
    input  logic [7:0] in_byte,
    output logic       dcx,
    output logic       wr,
    output logic [7:0] D,
    output logic       busy
);

    localparam int MAX_CYC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic             dcx_q;
    logic [7:0]       d_q;

    logic             pend_s;
    logic [8:0]       pend_word_s;
    logic             pop_s;

    // A byte is taken either from IDLE or exactly at the last WR_HI cycle (back-to-back writes).
    assign pop_s = pend_s && ((state_q == IDLE) ||
                              ((state_q == WR_HI) && (cnt_q == HI_LAST)));

`ifdef LCD_WR_FIFO_EN
    logic [8:0] fifo_q [4];
    logic [1:0] rd_ptr_q;
    logic [1:0] wr_ptr_q;
    logic [2:0] count_q;
    logic       push_s;

    // Ready depends only on occupancy, so a same-cycle pop never admits a push into a full FIFO.
    assign in_ready    = (count_q != 3'd4);
    assign push_s      = in_valid && in_ready;
    assign pend_s      = (count_q != 3'd0);
    assign pend_word_s = fifo_q[rd_ptr_q];
    assign busy        = (state_q != IDLE) || (count_q != 3'd0);

    // Input FIFO storage and pointers.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 9'h000;
            end
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= {in_dcx, in_byte};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push_s} - {2'b00, pop_s};
        end
    end
`else
    // Without a FIFO the upstream byte is consumed directly on the edge that starts its write.
    assign in_ready    = (state_q == IDLE);
    assign pend_s      = in_valid && in_ready;
    assign pend_word_s = {in_dcx, in_byte};
    assign busy        = (state_q != IDLE);
`endif

    // Write-cycle FSM with registered panel outputs.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            wr_q    <= 1'b1;
            dcx_q   <= 1'b0;
            d_q     <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        d_q     <= pend_word_s[7:0];
                        dcx_q   <= pend_word_s[8];
                        wr_q    <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                        state_q <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (cnt_q == LO_LAST) begin
                        wr_q    <= 1'b1;
                        cnt_q   <= CNT_ZERO;
                        state_q <= WR_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WR_HI: begin
                    if (cnt_q == HI_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (pop_s) begin
                            d_q     <= pend_word_s[7:0];
                            dcx_q   <= pend_word_s[8];
                            wr_q    <= 1'b0;
                            state_q <= WR_LO;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_ZERO;
                    wr_q    <= 1'b1;
                end
            endcase
        end
    end

    assign wr  = wr_q;
    assign dcx = dcx_q;
    assign D   = d_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: directed table, reset corner sequences and random traffic checked
// against a timing model that predicts each byte's write window from its start edge.
module tb_lcd_bus_writer;

    logic       hwclk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_dcx;
    logic [7:0] in_byte;

    logic       rdy_s  [2];
    logic       dcx_s  [2];
    logic       wr_s   [2];
    logic [7:0] d_s    [2];
    logic       busy_s [2];

    int n_err = 0;
    int n_chk = 0;

    always #5 hwclk = ~hwclk;

    lcd_bus_writer u_dut (
        .hwclk(hwclk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s[0]),
        .in_dcx(in_dcx), .in_byte(in_byte), .dcx(dcx_s[0]), .wr(wr_s[0]),
        .D(d_s[0]), .busy(busy_s[0])
    );

    lcd_bus_writer #(.WR_LOW_CYC(1), .WR_HIGH_CYC(1)) u_dut_fast (
        .hwclk(hwclk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s[1]),
        .in_dcx(in_dcx), .in_byte(in_byte), .dcx(dcx_s[1]), .wr(wr_s[1]),
        .D(d_s[1]), .busy(busy_s[1])
    );

    // Reference model: each instance remembers the edge its current byte started on.
    int         m_t;
    int         m_s  [2];
    logic [7:0] m_d  [2];
    logic       m_c  [2];
    int         m_fn [2];
`ifdef LCD_WR_FIFO_EN
    logic [8:0] m_fq [2][4];
`endif

    function automatic int lo_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int hi_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic model_reset(input int k);
        m_s[k]  = -1000;
        m_d[k]  = 8'h00;
        m_c[k]  = 1'b0;
        m_fn[k] = 0;
    endtask

    task automatic model_edge(input int k, input logic r, input logic v, input logic c,
                              input logic [7:0] b);
        int e;
        int per;
        e   = m_t + 1;
        per = lo_of(k) + hi_of(k);
        if (r) begin
            model_reset(k);
        end else begin
`ifdef LCD_WR_FIFO_EN
            logic       rdy;
            logic [8:0] w;
            rdy = (m_fn[k] < 4);
            if (m_fn[k] > 0 && e >= m_s[k] + per) begin
                w = m_fq[k][0];
                for (int i = 0; i < 3; i++) m_fq[k][i] = m_fq[k][i+1];
                m_fn[k] = m_fn[k] - 1;
                m_s[k]  = e;
                m_d[k]  = w[7:0];
                m_c[k]  = w[8];
            end
            if (v && rdy) begin
                m_fq[k][m_fn[k]] = {c, b};
                m_fn[k] = m_fn[k] + 1;
            end
`else
            if (v && e >= m_s[k] + per + 1) begin
                m_s[k] = e;
                m_d[k] = b;
                m_c[k] = c;
            end
`endif
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        int   lo;
        int   per;
        logic e_wr;
        logic e_busy;
        logic e_rdy;
        for (int k = 0; k < 2; k++) begin
            lo     = lo_of(k);
            per    = lo + hi_of(k);
            e_wr   = !(m_t >= m_s[k] && m_t < m_s[k] + lo);
            e_busy = (m_t < m_s[k] + per) || (m_fn[k] > 0);
`ifdef LCD_WR_FIFO_EN
            e_rdy  = (m_fn[k] < 4);
`else
            e_rdy  = (m_t >= m_s[k] + per);
`endif
            chk($sformatf("model_wr[%0d] t=%0d", k, m_t), {31'd0, wr_s[k]}, {31'd0, e_wr});
            chk($sformatf("model_D[%0d] t=%0d", k, m_t), {24'd0, d_s[k]}, {24'd0, m_d[k]});
            chk($sformatf("model_dcx[%0d] t=%0d", k, m_t), {31'd0, dcx_s[k]}, {31'd0, m_c[k]});
            chk($sformatf("model_busy[%0d] t=%0d", k, m_t), {31'd0, busy_s[k]}, {31'd0, e_busy});
            chk($sformatf("model_ready[%0d] t=%0d", k, m_t), {31'd0, rdy_s[k]}, {31'd0, e_rdy});
        end
    endtask

    // One clock: drive inputs, let both DUT and model take the edge, compare on the falling edge.
    task automatic cycle(input logic v, input logic c, input logic [7:0] b);
        in_valid = v;
        in_dcx   = c;
        in_byte  = b;
        @(posedge hwclk);
        for (int k = 0; k < 2; k++) model_edge(k, reset, v, c, b);
        m_t = m_t + 1;
        @(negedge hwclk);
        check_all();
    endtask

    typedef struct {
        logic       v;
        logic       c;
        logic [7:0] b;
        logic       e_wr;
        logic [7:0] e_d;
        logic       e_dcx;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    vec_t tbl [11];
    int   lows;

    initial begin
        // Default-parameter instance, no FIFO: 2A written, A5 refused while busy, retried in IDLE.
        tbl[0]  = '{1'b1, 1'b0, 8'h2A, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};

        m_t = 0;
        for (int k = 0; k < 2; k++) model_reset(k);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_dcx   = 1'b0;
        in_byte  = 8'h00;

        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hFF);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_wr[%0d]", k), {31'd0, wr_s[k]}, 32'd1);
            chk($sformatf("reset_D[%0d]", k), {24'd0, d_s[k]}, 32'd0);
            chk($sformatf("reset_busy[%0d]", k), {31'd0, busy_s[k]}, 32'd0);
            chk($sformatf("reset_ready[%0d]", k), {31'd0, rdy_s[k]}, 32'd1);
        end
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].c, tbl[i].b);
`ifndef LCD_WR_FIFO_EN
            chk($sformatf("tbl_wr[%0d]", i), {31'd0, wr_s[0]}, {31'd0, tbl[i].e_wr});
            chk($sformatf("tbl_D[%0d]", i), {24'd0, d_s[0]}, {24'd0, tbl[i].e_d});
            chk($sformatf("tbl_dcx[%0d]", i), {31'd0, dcx_s[0]}, {31'd0, tbl[i].e_dcx});
            chk($sformatf("tbl_busy[%0d]", i), {31'd0, busy_s[0]}, {31'd0, tbl[i].e_busy});
            chk($sformatf("tbl_ready[%0d]", i), {31'd0, rdy_s[0]}, {31'd0, tbl[i].e_rdy});
`endif
        end

        // Reset asynchronously during the low phase of the second of three bytes.
        cycle(1'b1, 1'b0, 8'h10);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h20);
        cycle(1'b1, 1'b1, 8'h30);
        chk("midwrite_wr_low_before_reset", {31'd0, wr_s[0]}, 32'd0);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_wr[%0d]", k), {31'd0, wr_s[k]}, 32'd1);
            chk($sformatf("async_busy[%0d]", k), {31'd0, busy_s[k]}, 32'd0);
            chk($sformatf("async_D[%0d]", k), {24'd0, d_s[k]}, 32'd0);
            chk($sformatf("async_dcx[%0d]", k), {31'd0, dcx_s[k]}, 32'd0);
            model_reset(k);
        end
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        lows  = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            if (wr_s[0] == 1'b0 || wr_s[1] == 1'b0) lows++;
        end
        chk("no_wr_after_reset", lows, 32'd0);

        // First edge after reset release must accept.
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 8'h77);
`ifndef LCD_WR_FIFO_EN
        chk("first_edge_wr", {31'd0, wr_s[0]}, 32'd0);
        chk("first_edge_D", {24'd0, d_s[0]}, 32'h77);
`endif
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00);

        // Back-to-back valid bursts then random traffic.
        for (int i = 0; i < 12; i++) cycle(1'b1, (i > 0) ? 1'b1 : 1'b0, 8'(8'h2C + 8'(i)));
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_bus_writer.md
LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 SHALL have parameter WR_LOW_CYC, default 2, cycles wr held low per byte (legal range >= 1).
REQ-002 SHALL have parameter WR_HIGH_CYC, default 2, cycles wr held high after each low phase (legal range >= 1).
REQ-003 SHALL have port hwclk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port in_dcx  input  1  0 = command byte, 1 = data byte.
REQ-008 SHALL have port in_byte  input  8  byte to write to the LCD.
REQ-009 SHALL have port dcx  output  1  LCD data/command select, registered.
REQ-010 SHALL have port wr  output  1  LCD write strobe, active-low, registered; the panel latches D on its rising edge.
REQ-011 SHALL have port D  output  8  LCD parallel data, registered.
REQ-012 SHALL have port busy  output  1  high while any byte is queued or a write cycle is in progress.

Function
REQ-013 SHALL accept a byte on a rising edge where in_valid and in_ready are both 1; no other edge transfers.
REQ-014 SHALL implement FSM states IDLE, WR_LO and WR_HI.
REQ-015 In IDLE with a byte pending, the FSM SHALL pop it on the next edge, load D/dcx, drive wr=0 on that same edge, and enter WR_LO.
REQ-016 SHALL hold wr=0 for exactly WR_LOW_CYC cycles in WR_LO, then drive wr=1 and enter WR_HI.
REQ-017 SHALL hold wr=1 for exactly WR_HIGH_CYC cycles in WR_HI.
REQ-018 At WR_HI exit with a byte pending, the FSM SHALL pop it and re-enter WR_LO directly, with no IDLE cycle; otherwise it SHALL go to IDLE.
REQ-019 Sustained throughput SHALL be one byte per WR_LOW_CYC+WR_HIGH_CYC cycles.
REQ-020 D and dcx SHALL be stable for the whole WR_LO/WR_HI window of a byte and SHALL hold their last value in IDLE.
REQ-021 Bytes SHALL appear on D in acceptance order, each with its own dcx.
REQ-022 Counters SHALL be sized for the parameter values and SHALL never wrap mid-phase.
REQ-023 busy SHALL equal (state != IDLE) OR (queue not empty).

Reset
REQ-024 While reset=1, outputs SHALL be wr=1, dcx=0, D=8'h00, busy=0, and the FSM SHALL be in IDLE.
REQ-025 While reset=1, the queue SHALL be empty.
REQ-026 Reset asserted mid-write SHALL force wr=1 immediately (asynchronous) and discard the current byte and all queued bytes.
REQ-027 The first rising edge after reset deassertion SHALL be able to accept a byte.

Configuration
REQ-028 Macro LCD_WR_FIFO_EN defined: input SHALL pass through a 4-entry FIFO.
REQ-029 With LCD_WR_FIFO_EN: in_ready = !full, combinational from FIFO state only; a pop in the same cycle SHALL NOT enable a push when full.
REQ-030 With LCD_WR_FIFO_EN: a byte accepted at edge N into an empty FIFO in IDLE SHALL drive wr=0 at edge N+1.
REQ-031 With LCD_WR_FIFO_EN: in_ready SHALL be 1 during reset.
REQ-032 Macro LCD_WR_FIFO_EN undefined: no FIFO; in_ready SHALL be 1 only in IDLE.
REQ-033 Without LCD_WR_FIFO_EN: a byte accepted at edge N SHALL load D/dcx and drive wr=0 at edge N (zero-cycle latency), and REQ-018 reduces to always returning to IDLE.

Verification
REQ-034 Single byte: reset, then push (dcx=0, 8'h2A) -> wr low 2 cycles then high 2 cycles, D=8'h2A, dcx=0, busy falls after WR_HI; FIFO on: wr falls 1 cycle after accept.
REQ-035 Burst with FIFO on: push 8'h2C (dcx=0), 8'h11, 8'h22, 8'h33 (dcx=1) back-to-back -> four low pulses at 4-cycle pitch, no IDLE gap, order and dcx preserved.
REQ-036 Full FIFO: hold in_valid with WR_LOW_CYC=3, WR_HIGH_CYC=3 -> in_ready drops after 4 queued bytes and re-rises only after a pop; no byte lost or duplicated across 10 bytes.
REQ-037 Reset mid-write: assert reset during WR_LO of the second of three bytes -> wr=1 within the same cycle, busy=0, D=8'h00, no further wr pulses after release.
REQ-038 FIFO off: push 8'hA5 (dcx=1) while busy -> in_ready=0 and the byte is not taken; retry in IDLE -> wr=0 on the accept edge.
REQ-039 Parameter sweep: WR_LOW_CYC=1, WR_HIGH_CYC=1 -> 2-cycle pitch with D stable across each rising wr edge.
